// File: rtl/div_unit.sv
// rtl/div_unit.sv - iterative radix-2 restoring divider for DIV/DIVU/REM/REMU
//
// Purpose: computes the quotient or remainder of two XLEN-bit operands one
// bit per cycle, stalling the execute stage while busy and returning one
// registered result with a single-cycle valid pulse.
//
// Ports:
//   clk, rst_n        core clock, asynchronous active-low reset
//   alu_operand_1_i   dividend
//   alu_operand_2_i   divisor
//   alu_d_ops_i       0 NONE, 1 DIV, 2 DIVU, 3 REM, 4 REMU (5-7 NONE)
//   div_flush_i       kill the in-flight operation
//   div_stall_o       hold EXE and upstream (combinational)
//   div_result_o      quotient or remainder, meaningful with div_valid_o
//   div_valid_o       result present this cycle
module div_unit #(
    parameter int XLEN  = 32,
    parameter int CNT_W = $clog2(XLEN)
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic [XLEN-1:0] alu_operand_1_i,
    input  logic [XLEN-1:0] alu_operand_2_i,
    input  logic [2:0]      alu_d_ops_i,
    input  logic            div_flush_i,
    output logic            div_stall_o,
    output logic [XLEN-1:0] div_result_o,
    output logic            div_valid_o
);

    localparam logic [2:0] OP_DIV  = 3'd1;
    localparam logic [2:0] OP_DIVU = 3'd2;
    localparam logic [2:0] OP_REM  = 3'd3;
    localparam logic [2:0] OP_REMU = 3'd4;

    localparam logic [XLEN-1:0] INT_MIN = {1'b1, {(XLEN-1){1'b0}}};

    typedef enum logic [1:0] {S_IDLE, S_BUSY, S_DONE} state_t;

    state_t          state;
    logic [CNT_W-1:0] cnt;
    logic [XLEN-1:0] rem_r;
    logic [XLEN-1:0] quo_r;
    logic [XLEN-1:0] dvs_r;
    logic            is_rem_r;
    logic            neg_q_r;
    logic            neg_r_r;
    logic [XLEN-1:0] result_r;
    logic            valid_r;

    // Decode of the presented operation
    logic            op_active;
    logic            op_signed;
    logic            op_is_rem;
    logic            a_neg;
    logic            b_neg;
    logic [XLEN-1:0] a_abs;
    logic [XLEN-1:0] b_abs;
    logic            div_zero;
    logic            overflow;
    logic [XLEN-1:0] fast_result;

    assign op_active = (alu_d_ops_i == OP_DIV) || (alu_d_ops_i == OP_DIVU) ||
                       (alu_d_ops_i == OP_REM) || (alu_d_ops_i == OP_REMU);
    assign op_signed = (alu_d_ops_i == OP_DIV) || (alu_d_ops_i == OP_REM);
    assign op_is_rem = (alu_d_ops_i == OP_REM) || (alu_d_ops_i == OP_REMU);
    assign a_neg     = op_signed & alu_operand_1_i[XLEN-1];
    assign b_neg     = op_signed & alu_operand_2_i[XLEN-1];
    assign a_abs     = a_neg ? -alu_operand_1_i : alu_operand_1_i;
    assign b_abs     = b_neg ? -alu_operand_2_i : alu_operand_2_i;
    assign div_zero  = (alu_operand_2_i == '0);
    assign overflow  = op_signed && (alu_operand_1_i == INT_MIN) && (alu_operand_2_i == '1);

    // Divide-by-zero wins over overflow since overflow needs a non-zero divisor anyway
    assign fast_result = op_is_rem ? (div_zero ? alu_operand_1_i : '0)
                                   : (div_zero ? '1 : INT_MIN);

    // One restoring step: shift {rem, quo} left, trial-subtract the divisor
    // one bit wider so the borrow out is the sign of the trial.
    logic [XLEN:0]   shift_rem;
    logic [XLEN:0]   trial;
    logic            trial_ok;
    logic [XLEN-1:0] rem_nxt;
    logic [XLEN-1:0] quo_nxt;
    logic [XLEN-1:0] quo_fix;
    logic [XLEN-1:0] rem_fix;

    assign shift_rem = {rem_r, quo_r[XLEN-1]};
    assign trial     = shift_rem - {1'b0, dvs_r};
    assign trial_ok  = ~trial[XLEN];
    assign rem_nxt   = trial_ok ? trial[XLEN-1:0] : shift_rem[XLEN-1:0];
    assign quo_nxt   = {quo_r[XLEN-2:0], trial_ok};
    assign quo_fix   = neg_q_r ? -quo_nxt : quo_nxt;
    assign rem_fix   = neg_r_r ? -rem_nxt : rem_nxt;

    assign div_stall_o  = rst_n & op_active & (state != S_DONE) & ~div_flush_i;
    assign div_result_o = result_r;
    assign div_valid_o  = valid_r;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= S_IDLE;
            cnt      <= '0;
            rem_r    <= '0;
            quo_r    <= '0;
            dvs_r    <= '0;
            is_rem_r <= 1'b0;
            neg_q_r  <= 1'b0;
            neg_r_r  <= 1'b0;
            result_r <= '0;
            valid_r  <= 1'b0;
        end else begin
            valid_r <= 1'b0;
            if (div_flush_i) begin
                state <= S_IDLE;
                cnt   <= '0;
            end else begin
                case (state)
                    S_IDLE: begin
                        if (op_active) begin
                            is_rem_r <= op_is_rem;
                            neg_q_r  <= a_neg ^ b_neg;
                            neg_r_r  <= a_neg;
                            if (div_zero || overflow) begin
                                result_r <= fast_result;
                                valid_r  <= 1'b1;
                                state    <= S_DONE;
                            end else begin
                                cnt   <= CNT_W'(XLEN-1);
                                rem_r <= '0;
                                quo_r <= a_abs;
                                dvs_r <= b_abs;
                                state <= S_BUSY;
                            end
                        end
                    end
                    S_BUSY: begin
                        rem_r <= rem_nxt;
                        quo_r <= quo_nxt;
                        cnt   <= cnt - 1'b1;
                        if (cnt == '0) begin
                            // Sign correction is folded into the final step
                            result_r <= is_rem_r ? rem_fix : quo_fix;
                            valid_r  <= 1'b1;
                            state    <= S_DONE;
                        end
                    end
                    S_DONE: begin
                        state <= S_IDLE;
                    end
                    default: begin
                        state <= S_IDLE;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_div_unit.sv
// tb/tb_div_unit.sv - self-checking bench for div_unit
module tb_div_unit;

    logic        clk;
    logic        rst_n;
    logic [31:0] opa;
    logic [31:0] opb;
    logic [2:0]  ops;
    logic        flush;
    logic        stall;
    logic [31:0] result;
    logic        valid;

    int checks   = 0;
    int failures = 0;

    div_unit #(.XLEN(32)) dut (
        .clk             (clk),
        .rst_n           (rst_n),
        .alu_operand_1_i (opa),
        .alu_operand_2_i (opb),
        .alu_d_ops_i     (ops),
        .div_flush_i     (flush),
        .div_stall_o     (stall),
        .div_result_o    (result),
        .div_valid_o     (valid)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // RISC-V M-extension semantics in plain arithmetic
    function automatic logic [31:0] model(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
        int  sa;
        int  sb;
        logic ovf;
        sa  = a;
        sb  = b;
        ovf = (a == 32'h8000_0000) && (b == 32'hFFFF_FFFF);
        case (op)
            3'd1: return (b == 0) ? 32'hFFFF_FFFF : ovf ? 32'h8000_0000 : 32'(sa / sb);
            3'd2: return (b == 0) ? 32'hFFFF_FFFF : a / b;
            3'd3: return (b == 0) ? a : ovf ? 32'd0 : 32'(sa % sb);
            3'd4: return (b == 0) ? a : a % b;
            default: return 32'd0;
        endcase
    endfunction

    // Presents an op at a negedge (cycle 0) and follows it to its valid pulse.
    // Returns at the negedge of the DONE cycle with the op still held.
    task automatic run_op(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b, input string tag);
        logic [31:0] exp;
        int          exp_lat;
        int          lat;
        logic        stall_ok;
        logic        got;
        exp     = model(op, a, b);
        exp_lat = ((b == 0) || ((op == 3'd1 || op == 3'd3) && a == 32'h8000_0000 && b == 32'hFFFF_FFFF)) ? 1 : 33;
        @(negedge clk);
        ops = op; opa = a; opb = b;
        #1;
        check({tag, "_stall_c0"}, 32'(stall), 32'd1);
        lat      = 0;
        stall_ok = 1'b1;
        got      = 1'b0;
        for (int k = 1; k <= 40 && !got; k++) begin
            @(negedge clk);
            if (valid) begin
                got = 1'b1;
                lat = k;
                check({tag, "_stall_done"}, 32'(stall), 32'd0);
                check({tag, "_result"}, result, exp);
            end else if (!stall) begin
                stall_ok = 1'b0;
            end
        end
        check({tag, "_latency"}, 32'(lat), 32'(exp_lat));
        check({tag, "_stall_busy"}, 32'(stall_ok), 32'd1);
    endtask

    task automatic go_idle();
        @(negedge clk);
        ops = 3'd0;
    endtask

    task automatic expect_quiet(input int cycles, input string tag);
        logic seen;
        seen = 1'b0;
        for (int k = 0; k < cycles; k++) begin
            @(negedge clk);
            if (valid) seen = 1'b1;
        end
        check(tag, 32'(seen), 32'd0);
    endtask

    initial begin
        logic [2:0]  rop;
        logic [31:0] ra;
        logic [31:0] rb;
        int          sel;

        rst_n = 1'b0; ops = 3'd0; opa = '0; opb = '0; flush = 1'b0;
        #1;
        check("reset_result", result, 32'd0);
        check("reset_valid", 32'(valid), 32'd0);
        check("reset_stall", 32'(stall), 32'd0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;

        run_op(3'd2, 32'd100, 32'd7, "divu_100_7");     go_idle();
        run_op(3'd4, 32'd100, 32'd7, "remu_100_7");     go_idle();
        run_op(3'd1, -32'sd7, 32'd2, "div_m7_2");       go_idle();
        run_op(3'd3, -32'sd7, 32'd2, "rem_m7_2");       go_idle();
        run_op(3'd1, 32'd7, -32'sd2, "div_7_m2");       go_idle();
        run_op(3'd3, 32'd7, -32'sd2, "rem_7_m2");       go_idle();
        run_op(3'd2, 32'd5, 32'd0, "divu_by0");         go_idle();
        run_op(3'd3, 32'd5, 32'd0, "rem_by0");          go_idle();
        run_op(3'd1, 32'h8000_0000, 32'hFFFF_FFFF, "div_ovf"); go_idle();
        run_op(3'd3, 32'h8000_0000, 32'hFFFF_FFFF, "rem_ovf"); go_idle();

        // Back-to-back: second op presented the cycle after DONE
        run_op(3'd2, 32'hFFFF_FFFF, 32'd1, "b2b_divu");
        run_op(3'd4, 32'hFFFF_FFFF, 32'h10, "b2b_remu");
        go_idle();

        // Codes 5-7 behave as NONE
        for (int c = 5; c <= 7; c++) begin
            @(negedge clk);
            ops = 3'(c); opa = 32'd9; opb = 32'd3;
            #1;
            check("none_code_stall", 32'(stall), 32'd0);
        end
        expect_quiet(3, "none_code_valid");
        go_idle();

        // Flush at cycle 10 of a BUSY op
        @(negedge clk);
        ops = 3'd2; opa = 32'd1000; opb = 32'd3;
        repeat (10) @(negedge clk);
        flush = 1'b1;
        #1;
        check("flush_stall", 32'(stall), 32'd0);
        @(negedge clk);
        flush = 1'b0; ops = 3'd0;
        check("flush_valid_next", 32'(valid), 32'd0);
        expect_quiet(40, "flush_no_valid");

        // Asynchronous reset at cycle 5 of a BUSY op
        @(negedge clk);
        ops = 3'd2; opa = 32'd12345; opb = 32'd11;
        repeat (5) @(negedge clk);
        rst_n = 1'b0;
        #1;
        check("rst_mid_valid", 32'(valid), 32'd0);
        check("rst_mid_stall", 32'(stall), 32'd0);
        check("rst_mid_result", result, 32'd0);
        ops = 3'd0;
        @(negedge clk);
        rst_n = 1'b1;
        expect_quiet(40, "rst_no_valid");
        run_op(3'd2, 32'd12345, 32'd11, "after_rst");   go_idle();

        // Randomized ops against the reference model
        for (int i = 0; i < 24; i++) begin
            rop = 3'($urandom_range(1, 4));
            ra  = $urandom;
            sel = $urandom_range(0, 7);
            case (sel)
                0: rb = 32'd0;
                1: rb = 32'($urandom_range(1, 15));
                2: rb = 32'hFFFF_FFFF;
                3: begin ra = 32'h8000_0000; rb = 32'hFFFF_FFFF; end
                default: rb = $urandom;
            endcase
            run_op(rop, ra, rb, "rand");
            go_idle();
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
